// File: rtl/alu_stack_pkg.sv
// Shared constants, FSM state type and helpers for the ALU operand-stack front end.
// The optional opcode filter in the top is enabled by defining ALU_OPCODE_CHECK_EN.
package alu_stack_pkg;

    localparam logic [7:0] OP_ADD = 8'h07;
    localparam logic [7:0] OP_SUB = 8'h08;
    localparam logic [7:0] OP_AND = 8'h09;
    localparam logic [7:0] OP_OR  = 8'h0A;
    localparam logic [7:0] OP_XOR = 8'h0B;

    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_POP  = 2'b01;
    localparam logic [1:0] CMD_ALU  = 2'b10;
    localparam logic [1:0] CMD_DROP = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDrive   = 2'd1,
        StCapture = 2'd2
    } state_e;

    // Width of a counter that must represent 0..entries inclusive.
    function automatic int unsigned depth_w(input int unsigned entries);
        return $clog2(entries + 1);
    endfunction

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Operand storage: DEPTH x DATA_W registers, one write port, combinational TOS/NOS reads.
// Contents are not reset; the controller's depth count decides which entries are valid.
module stack_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  tos_idx,
    output logic [DATA_W-1:0] tos_data,
    output logic [DATA_W-1:0] nos_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  nos_idx;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Clamp keeps the read in range when fewer than two entries exist.
    assign nos_idx  = (tos_idx == '0) ? '0 : tos_idx - IDX_W'(1);
    assign tos_data = mem[tos_idx];
    assign nos_data = mem[nos_idx];

endmodule

// File: rtl/alu_stack_ctrl.sv
// Forth-style operand stack that issues two-cycle ALU bus transactions and pushes results.
// Define ALU_OPCODE_CHECK_EN to reject ALU commands whose opcode is outside ADD..XOR.
module alu_stack_ctrl
    import alu_stack_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        err,
    output logic [depth_w(DEPTH)-1:0]   depth,
    output logic [DATA_W-1:0]           tos,
    output logic                        alu_ena,
    output logic [DATA_W-1:0]           alu_opcode,
    output logic [DATA_W-1:0]           alu_oper0,
    output logic [DATA_W-1:0]           alu_oper1,
    input  logic [DATA_W-1:0]           data_bus
);

    localparam int unsigned    DW   = depth_w(DEPTH);
    localparam int unsigned    IW   = $clog2(DEPTH);
    localparam logic [DW-1:0]  FULL = DW'(DEPTH);

    state_e            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q, err_d;
    logic              alu_ena_q, alu_ena_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] oper0_q, oper0_d;
    logic [DATA_W-1:0] oper1_q, oper1_d;

    logic              we;
    logic [IW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [IW-1:0]     tos_idx;
    logic [DATA_W-1:0] tos_raw, nos_raw;
    logic              op_ok;

`ifdef ALU_OPCODE_CHECK_EN
    assign op_ok = is_alu_op(cmd_data);
`else
    assign op_ok = 1'b1;
`endif

    assign tos_idx = IW'(depth_q - DW'(1));

    stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IW)
    ) u_stack_mem (
        .clk      (clk),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .tos_idx  (tos_idx),
        .tos_data (tos_raw),
        .nos_data (nos_raw)
    );

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        alu_ena_d   = alu_ena_q;
        opcode_d    = opcode_q;
        oper0_d     = oper0_q;
        oper1_d     = oper1_q;
        we          = 1'b0;
        waddr       = tos_idx;
        wdata       = cmd_data;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        CMD_PUSH: begin
                            if (depth_q != FULL) begin
                                we      = 1'b1;
                                waddr   = IW'(depth_q);
                                depth_d = depth_q + DW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_POP, CMD_DROP: begin
                            if (depth_q != '0) begin
                                depth_d = depth_q - DW'(1);
                                if (cmd_op == CMD_POP) begin
                                    rsp_valid_d = 1'b1;
                                    rsp_data_d  = tos_raw;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if ((depth_q >= DW'(2)) && op_ok) begin
                                opcode_d  = cmd_data;
                                oper0_d   = tos_raw;
                                oper1_d   = nos_raw;
                                alu_ena_d = 1'b0;
                                state_d   = StDrive;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StDrive: begin
                state_d = StCapture;
            end
            StCapture: begin
                // Result lands in the NOS slot; TOS is consumed by the depth decrement.
                we        = 1'b1;
                waddr     = tos_idx - IW'(1);
                wdata     = data_bus;
                depth_d   = depth_q - DW'(1);
                alu_ena_d = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                alu_ena_d = 1'b1;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            depth_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            alu_ena_q   <= 1'b1;
            opcode_q    <= '0;
            oper0_q     <= '0;
            oper1_q     <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            alu_ena_q   <= alu_ena_d;
            opcode_q    <= opcode_d;
            oper0_q     <= oper0_d;
            oper1_q     <= oper1_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err        = err_q;
    assign depth      = depth_q;
    assign tos        = (depth_q == '0) ? '0 : tos_raw;
    assign alu_ena    = alu_ena_q;
    assign alu_opcode = opcode_q;
    assign alu_oper0  = oper0_q;
    assign alu_oper1  = oper1_q;

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Self-checking bench for alu_stack_ctrl: directed table, reset/corner sequences and
// randomized commands checked against a queue-based stack model.
module tb_alu_stack_ctrl;
    import alu_stack_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_data;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic          err;
    logic [DW-1:0] depth;
    logic [7:0]    tos;
    logic          alu_ena;
    logic [7:0]    alu_opcode;
    logic [7:0]    alu_oper0;
    logic [7:0]    alu_oper1;
    logic [7:0]    data_bus;

    int nvec  = 0;
    int nfail = 0;

    alu_stack_ctrl #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .err        (err),
        .depth      (depth),
        .tos        (tos),
        .alu_ena    (alu_ena),
        .alu_opcode (alu_opcode),
        .alu_oper0  (alu_oper0),
        .alu_oper1  (alu_oper1),
        .data_bus   (data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] opc, input logic [7:0] a0,
                                         input logic [7:0] a1);
        case (opc)
            8'h07:   return a1 + a0;
            8'h08:   return a1 - a0;
            8'h09:   return a1 & a0;
            8'h0A:   return a1 | a0;
            8'h0B:   return a1 ^ a0;
            default: return 8'h00;
        endcase
    endfunction

    // ALU device: drives the bus only while enabled, junk otherwise to expose mistimed sampling.
    assign data_bus = alu_ena ? 8'h5A : alu_f(alu_opcode, alu_oper0, alu_oper1);

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] tos;
        int         depth;
        logic       err;
        logic       rsp;
        logic [7:0] rdata;
        int         ena_low;
        logic [7:0] o0;
        logic [7:0] o1;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] stk[$];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [7:0] d, input logic [7:0] t,
                       input int dep, input logic e, input logic r, input logic [7:0] rd,
                       input int en, input logic [7:0] o0, input logic [7:0] o1);
        vec_t v;
        v = '{op, d, t, dep, e, r, rd, en, o0, o1};
        tbl.push_back(v);
    endtask

    // Reference model: plain LIFO semantics, top of stack at the back of the queue.
    task automatic model(input logic [1:0] op, input logic [7:0] d, output vec_t e);
        logic       bad;
        logic [7:0] a0, a1;
        e = '{op, d, 8'h00, 0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 8'h00};
        case (op)
            CMD_PUSH: begin
                if (stk.size() < DEPTH) stk.push_back(d);
                else e.err = 1'b1;
            end
            CMD_POP, CMD_DROP: begin
                if (stk.size() > 0) begin
                    a0 = stk.pop_back();
                    if (op == CMD_POP) begin
                        e.rsp   = 1'b1;
                        e.rdata = a0;
                    end
                end else begin
                    e.err = 1'b1;
                end
            end
            default: begin
`ifdef ALU_OPCODE_CHECK_EN
                bad = !(d >= 8'h07 && d <= 8'h0B);
`else
                bad = 1'b0;
`endif
                if (bad || stk.size() < 2) begin
                    e.err = 1'b1;
                end else begin
                    a0 = stk.pop_back();
                    a1 = stk.pop_back();
                    stk.push_back(alu_f(d, a0, a1));
                    e.o0      = a0;
                    e.o1      = a1;
                    e.ena_low = 2;
                end
            end
        endcase
        e.depth = stk.size();
        e.tos   = (stk.size() > 0) ? stk[$] : 8'h00;
    endtask

    task automatic apply(input string tag, input vec_t e);
        logic       g_err, g_rsp;
        logic [7:0] g_rd, g_o0, g_o1;
        int         ena, lat;
        @(posedge clk);
        #1;
        chk({tag, " idle_quiet"}, {err, rsp_valid, cmd_ready, alu_ena}, 4'b0011);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = e.op;
        cmd_data  = e.data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        g_err = 1'b0;
        g_rsp = 1'b0;
        g_rd  = 8'h00;
        g_o0  = 8'h00;
        g_o1  = 8'h00;
        ena   = 0;
        lat   = 1;
        for (int k = 0; k < 20; k++) begin
            g_err |= err;
            if (rsp_valid) begin
                g_rsp = 1'b1;
                g_rd  = rsp_data;
            end
            if (!alu_ena) begin
                ena++;
                if (ena == 1) begin
                    g_o0 = alu_oper0;
                    g_o1 = alu_oper1;
                end
            end
            if (cmd_ready) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " err"}, g_err, e.err);
        chk({tag, " rsp_valid"}, g_rsp, e.rsp);
        if (e.rsp) chk({tag, " rsp_data"}, g_rd, e.rdata);
        chk({tag, " ena_low"}, ena, e.ena_low);
        chk({tag, " latency"}, lat, (e.ena_low == 2) ? 3 : 1);
        chk({tag, " tos"}, tos, e.tos);
        chk({tag, " depth"}, depth, e.depth);
        if (e.ena_low == 2) begin
            chk({tag, " oper0"}, g_o0, e.o0);
            chk({tag, " oper1"}, g_o1, e.o1);
            chk({tag, " opcode"}, alu_opcode, e.data);
        end
    endtask

    task automatic run_model(input string tag, input logic [1:0] op, input logic [7:0] d);
        vec_t e;
        model(op, d, e);
        apply(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       m;
        logic [1:0] rop;
        logic [7:0] rd;
        int         r;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset depth", depth, 0);
        chk("reset alu_ena", alu_ena, 1);
        chk("reset opcode/opers", {alu_opcode, alu_oper0, alu_oper1}, 0);
        chk("reset rsp/err", {rsp_valid, err, rsp_data}, 0);
        chk("reset tos", tos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset cmd_ready", cmd_ready, 1);

        add(CMD_PUSH, 8'h05, 8'h05, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_PUSH, 8'h03, 8'h03, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_ALU,  8'h07, 8'h08, 1, 0, 0, 8'h00, 2, 8'h03, 8'h05);
        add(CMD_POP,  8'h00, 8'h00, 0, 0, 1, 8'h08, 0, 8'h00, 8'h00);
        add(CMD_PUSH, 8'h03, 8'h03, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_PUSH, 8'h05, 8'h05, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_ALU,  8'h08, 8'hFE, 1, 0, 0, 8'h00, 2, 8'h05, 8'h03);
        add(CMD_PUSH, 8'h0F, 8'h0F, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_ALU,  8'h09, 8'h0E, 1, 0, 0, 8'h00, 2, 8'h0F, 8'hFE);
        add(CMD_ALU,  8'h0B, 8'h0E, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_DROP, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_POP,  8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_DROP, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++)
            add(CMD_PUSH, 8'(8'h11 * (i + 1)), 8'(8'h11 * (i + 1)), i + 1, 0, 0, 8'h00, 0,
                8'h00, 8'h00);
        add(CMD_PUSH, 8'hAA, 8'(8'h11 * DEPTH), DEPTH, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        for (int i = DEPTH - 1; i >= 0; i--)
            add(CMD_POP, 8'h00, 8'(8'h11 * i), i, 0, 1, 8'(8'h11 * (i + 1)), 0, 8'h00, 8'h00);
        add(CMD_POP,  8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_PUSH, 8'h0F, 8'h0F, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_PUSH, 8'hF0, 8'hF0, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_ALU,  8'h0A, 8'hFF, 1, 0, 0, 8'h00, 2, 8'hF0, 8'h0F);
        add(CMD_PUSH, 8'h3C, 8'h3C, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(CMD_ALU,  8'h0B, 8'hC3, 1, 0, 0, 8'h00, 2, 8'h3C, 8'hFF);
        add(CMD_DROP, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00);

        foreach (tbl[i]) begin
            model(tbl[i].op, tbl[i].data, m);
            apply($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Reset while the ALU transaction is in its drive phase.
        run_model("rst_pre0", CMD_PUSH, 8'h21);
        run_model("rst_pre1", CMD_PUSH, 8'h43);
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = CMD_ALU;
        cmd_data  = 8'h07;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("drive alu_ena", alu_ena, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst alu_ena", alu_ena, 1);
        chk("midrst depth", depth, 0);
        chk("midrst tos", tos, 0);
        stk.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst cmd_ready", cmd_ready, 1);
        chk("midrst still released", {alu_ena, depth}, {1'b1, DW'(0)});

        // Unknown opcode: filtered with the check enabled, ALU returns 0 otherwise.
        run_model("ff_push0", CMD_PUSH, 8'h12);
        run_model("ff_push1", CMD_PUSH, 8'h34);
        run_model("ff_alu", CMD_ALU, 8'hFF);
        run_model("ff_drop", CMD_DROP, 8'h00);
        run_model("ff_drop2", CMD_DROP, 8'h00);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            rd = 8'($urandom);
            if (r <= 3) begin
                rop = CMD_PUSH;
            end else if (r == 4) begin
                rop = CMD_POP;
            end else if (r == 5) begin
                rop = CMD_DROP;
            end else begin
                rop = CMD_ALU;
                if ($urandom_range(0, 15) != 0) rd = 8'(8'h07 + $urandom_range(0, 4));
            end
            run_model($sformatf("rnd[%0d]", n), rop, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/alu_stack_ctrl.md
Name: alu_stack_ctrl

Overview:
- Forth-style operand-stack front end that acts as the initiator and reader for the 8-bit ALU on the shared tri-state data bus.
- Accepts PUSH/POP/DROP/ALU commands over a valid/ready port and keeps a LIFO of operands.
- For ALU commands it drives opcode and operands, asserts the active-low ALU enable, samples the data bus, and pushes the result.
- Sits between the instruction decoder and the ALU/data-bus fabric.

Parameters:
DEPTH, 8, number of stack entries (>=2)
DATA_W, 8, operand/bus width; fixed at 8 to match the ALU

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  2  00 PUSH, 01 POP, 10 ALU, 11 DROP
cmd_data  input  8  PUSH value, or ALU opcode for ALU
rsp_valid  output  1  one-cycle pulse: rsp_data holds popped value
rsp_data  output  8  popped value
err  output  1  one-cycle pulse on rejected command
depth  output  clog2(DEPTH+1)  current entry count
tos  output  8  top of stack (0 when empty)
alu_ena  output  1  ALU enable, active low; 1 = ALU bus released (high-Z)
alu_opcode  output  8  opcode to ALU
alu_oper0  output  8  ALU operand 0 = TOS
alu_oper1  output  8  ALU operand 1 = next-on-stack (NOS)
data_bus  input  8  shared data bus, sampled only while alu_ena=0

Behaviour:
- Reset (async, immediate): state IDLE, depth=0, alu_ena=1, alu_opcode/oper0/oper1=0, rsp_valid=0, rsp_data=0, err=0, cmd_ready=1 after deassert. Reset mid-ALU releases the bus at once; the in-flight result is discarded.
- FSM states:
  - IDLE: cmd_ready=1; handles accepted commands.
  - DRIVE: cmd_ready=0; alu_ena=0; opcode/operands stable; bus settles.
  - CAPTURE: alu_ena=0; data_bus registered into the stack; then IDLE.
- Opcode/operand outputs are registered in IDLE on acceptance and held until the next ALU command.
- alu_ena is registered low on entry to DRIVE and high on exit from CAPTURE: exactly 2 low cycles per ALU op.
- PUSH: depth<DEPTH → entry written, depth+1; full → err, no change. Single cycle, stays IDLE.
- POP: depth>0 → rsp_valid=1 next cycle with old TOS, depth-1; empty → err, no rsp.
- DROP: as POP but with no rsp_valid.
- ALU: requires depth>=2; otherwise err and stay IDLE.
  - Accepted: IDLE→DRIVE→CAPTURE→IDLE.
  - Result overwrites NOS slot; depth-1.
  - New TOS visible the cycle after CAPTURE: command at cycle 0 → tos valid at cycle 3, cmd_ready high again at cycle 3.
- Opcode semantics belong to the ALU: 07 ADD, 08 SUB (oper1-oper0 = NOS-TOS, Forth order), 09 AND, 0A OR, 0B XOR. Arithmetic wraps mod 256; no carry is kept.
- err and rsp_valid are never asserted together; each is at most one pulse per command.
- Commands arriving while cmd_ready=0 are held by the source (no drop).

Optional Feature:
- Macro: ALU_OPCODE_CHECK_EN.
- Defined: ALU commands with cmd_data outside 07..0B pulse err, leave the stack unchanged, and never assert alu_ena.
- Undefined: any opcode is forwarded; the ALU returns 0 for unknown codes, and 0 replaces the two operands (depth-1).

Decomposition:
- Package alu_stack_pkg holds:
  - opcode constants OP_ADD..OP_XOR;
  - cmd_op encodings CMD_PUSH/POP/ALU/DROP;
  - FSM state enum;
  - depth width function.
- Sub-module stack_mem: DEPTH×8 register array with write port and combinational TOS/NOS read. No reset on contents; depth is the validity reference.

Test Plan:
- PUSH 05, PUSH 03, ALU 07 → alu_ena low exactly 2 cycles, oper1=05, oper0=03, tos=08, depth=1.
- PUSH 03, PUSH 05, ALU 08 → tos=FE (wrap); PUSH 0F, ALU 09 (0F & FE) → tos=0E.
- Fill DEPTH entries, PUSH AA → err pulse, depth=DEPTH; POP ×DEPTH returns values in reverse order; extra POP → err, no rsp_valid.
- depth=1, ALU 0B → err, alu_ena stays 1, depth=1.
- rst_n asserted during DRIVE → alu_ena=1 same cycle, depth=0, cmd_ready=1 after release.
- ALU 0xFF with macro: err, no bus cycle; without macro: tos=00, depth-1.
